// File: rtl/transfer_packet_parser_pkg.sv
// Shared types and constants for the transfer packet parser.
package transfer_pkg;

    typedef enum logic [1:0] {
        HDR         = 2'd0,
        BODY        = 2'd1,
        EMIT_DEBIT  = 2'd2,
        EMIT_CREDIT = 2'd3
    } state_t;

    localparam logic       KIND_DEBIT   = 1'b0;
    localparam logic       KIND_CREDIT  = 1'b1;
    localparam logic [1:0] CMD_TRANSFER = 2'd2;

    // Counter bits needed to index the longer of the header and body phases.
    function automatic int byte_cnt_bits(input int hdr_bytes, input int body_bytes);
        int max_cnt;
        max_cnt = (hdr_bytes > body_bytes) ? hdr_bytes : body_bytes;
        return (max_cnt < 2) ? 1 : $clog2(max_cnt);
    endfunction

endpackage

// File: rtl/transfer_packet_parser_byte_shift_assembler.sv
// MSB-first byte shift register: each load shifts the held word left by one byte
// and inserts the new byte at the bottom.
module byte_shift_assembler #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [7:0]   i_byte,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;
    logic [W-1:0] w_next;

    generate
        if (W > 8) begin : g_wide
            assign w_next = {r_data[W-9:0], i_byte};
        end else begin : g_byte
            assign w_next = i_byte;
        end
    endgenerate

    // Shift register update; clear wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= w_next;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/transfer_packet_parser.sv
// Byte-stream parser for key/value transfer packets: skips the header, assembles
// sender/receiver/value big-endian, then emits a debit followed by a credit.
module transfer_packet_parser
    import transfer_pkg::*;
#(
    parameter int         KEY_W        = 32,
    parameter int         VAL_W        = 32,
    parameter int         HDR_BYTES    = 3,
    parameter logic [1:0] CMD_TRANSFER = transfer_pkg::CMD_TRANSFER,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_cmd,
    output logic             out_kind,
    output logic [KEY_W-1:0] out_key,
    output logic [VAL_W-1:0] out_value,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int BODY_BYTES = 2 * (KEY_W / 8) + VAL_W / 8;
    localparam int ASM_W      = 2 * KEY_W + VAL_W;
    localparam int BC_W       = byte_cnt_bits(HDR_BYTES, BODY_BYTES);

    localparam state_t          START_STATE = (HDR_BYTES == 0) ? BODY : HDR;
    localparam logic [BC_W-1:0] HDR_LAST    = BC_W'((HDR_BYTES == 0) ? 0 : HDR_BYTES - 1);
    localparam logic [BC_W-1:0] BODY_LAST   = BC_W'(BODY_BYTES - 1);
    localparam logic [BC_W-1:0] CNT_ONE     = BC_W'(1);

    state_t             r_state;
    logic [BC_W-1:0]    r_byte_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_out_kind;
    logic [KEY_W-1:0]   r_out_key;
    logic [VAL_W-1:0]   r_out_value;
    logic [1:0]         r_out_cmd;
    logic [KEY_W-1:0]   r_recv_key;
    logic               r_pkt_done;
    logic [CNT_W-1:0]   r_pkt_count;

    logic               w_parsing;
    logic               w_asm_clear;
    logic               w_asm_load;
    logic [ASM_W-9:0]   w_asm_data;
    logic [ASM_W-1:0]   w_body_full;
    logic [KEY_W-1:0]   w_sender;
    logic [KEY_W-1:0]   w_receiver;
    logic [VAL_W-1:0]   w_value;

    assign w_parsing   = (r_state == HDR) || (r_state == BODY);
    assign w_asm_clear = abort && w_parsing;
    assign w_asm_load  = in_valid && r_in_ready && !abort && (r_state == BODY);

    // The register holds all but the final body byte, which is taken straight
    // from in_byte so the debit can be presented on the very next edge.
    byte_shift_assembler #(
        .W (ASM_W - 8)
    ) u_body_asm (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_asm_clear),
        .i_load  (w_asm_load),
        .i_byte  (in_byte),
        .o_data  (w_asm_data)
    );

    assign w_body_full = {w_asm_data, in_byte};
    assign w_sender    = w_body_full[ASM_W-1 -: KEY_W];
    assign w_receiver  = w_body_full[VAL_W +: KEY_W];
    assign w_value     = w_body_full[VAL_W-1:0];

    // Parser/emitter state machine; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= START_STATE;
            r_byte_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_kind  <= KIND_DEBIT;
            r_out_key   <= '0;
            r_out_value <= '0;
            r_out_cmd   <= 2'd0;
            r_recv_key  <= '0;
            r_pkt_done  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                HDR: begin
                    if (abort) begin
                        r_byte_cnt <= '0;
                        r_state    <= START_STATE;
                    end else if (in_valid) begin
                        if (r_byte_cnt == HDR_LAST) begin
                            r_byte_cnt <= '0;
                            r_state    <= BODY;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_ONE;
                        end
                    end
                end
                BODY: begin
                    if (abort) begin
                        r_byte_cnt <= '0;
                        r_state    <= START_STATE;
                    end else if (in_valid) begin
                        if (r_byte_cnt == BODY_LAST) begin
                            r_byte_cnt  <= '0;
                            r_state     <= EMIT_DEBIT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_kind  <= KIND_DEBIT;
                            r_out_key   <= w_sender;
                            r_out_value <= w_value;
                            r_out_cmd   <= CMD_TRANSFER;
                            r_recv_key  <= w_receiver;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_ONE;
                        end
                    end
                end
                // abort is deliberately ignored while a transaction is presented.
                EMIT_DEBIT: begin
                    if (out_ready) begin
                        r_out_kind <= KIND_CREDIT;
                        r_out_key  <= r_recv_key;
                        r_state    <= EMIT_CREDIT;
                    end
                end
                EMIT_CREDIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pkt_done  <= 1'b1;
                        r_pkt_count <= r_pkt_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_in_ready  <= 1'b1;
                        r_state     <= START_STATE;
                    end
                end
                default: begin
                    r_state     <= START_STATE;
                    r_byte_cnt  <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_cmd   = r_out_cmd;
    assign out_kind  = r_out_kind;
    assign out_key   = r_out_key;
    assign out_value = r_out_value;
    assign pkt_done  = r_pkt_done;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_transfer_packet_parser.sv
// Directed plus randomized bench for transfer_packet_parser, checked against a
// packet-level model of expected debit/credit transactions.
module tb_transfer_packet_parser;

    typedef struct packed {
        logic        kind;
        logic [31:0] key;
        logic [31:0] value;
        logic [1:0]  cmd;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: 32-bit keys/value, 3 header bytes, 4-bit packet counter.
    logic [7:0]  a_in_byte;
    logic        a_in_valid, a_in_ready, a_abort, a_out_valid, a_out_ready;
    logic [1:0]  a_out_cmd;
    logic        a_out_kind, a_pkt_done;
    logic [31:0] a_out_key, a_out_value;
    logic [3:0]  a_pkt_count;

    // Instance B: 16-bit keys, 64-bit value, no header.
    logic [7:0]  b_in_byte;
    logic        b_in_valid, b_in_ready, b_abort, b_out_valid, b_out_ready;
    logic [1:0]  b_out_cmd;
    logic        b_out_kind, b_pkt_done;
    logic [15:0] b_out_key;
    logic [63:0] b_out_value;
    logic [15:0] b_pkt_count;

    transfer_packet_parser #(
        .KEY_W(32), .VAL_W(32), .HDR_BYTES(3), .CMD_TRANSFER(2'd2), .CNT_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .in_byte(a_in_byte), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .abort(a_abort), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_cmd(a_out_cmd), .out_kind(a_out_kind),
        .out_key(a_out_key), .out_value(a_out_value), .pkt_done(a_pkt_done),
        .pkt_count(a_pkt_count)
    );

    transfer_packet_parser #(
        .KEY_W(16), .VAL_W(64), .HDR_BYTES(0), .CMD_TRANSFER(2'd2), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .in_byte(b_in_byte), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .abort(b_abort), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_cmd(b_out_cmd), .out_kind(b_out_kind),
        .out_key(b_out_key), .out_value(b_out_value), .pkt_done(b_pkt_done),
        .pkt_count(b_pkt_count)
    );

    int checks = 0;
    int failures = 0;

    txn_t obs_q[$];
    int   done_cnt = 0;
    int   overlap_cnt = 0;

    txn_t exp_q[$];
    int   exp_rd = 0;
    int   obs_rd = 0;
    int   total_pkts = 0;
    int   pkts_since_rst = 0;

    // Monitor for instance A, sampled on the falling edge.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            obs_q.push_back('{kind: a_out_kind, key: a_out_key, value: a_out_value, cmd: a_out_cmd});
        end
        if (a_pkt_done) begin
            done_cnt <= done_cnt + 1;
        end
        if (a_out_valid && a_in_ready) begin
            overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pkts_since_rst = 0;
        obs_rd = obs_q.size();
    endtask

    // Present one byte after `gap` idle cycles and hold it until accepted.
    task automatic send_byte(input bit to_b, input logic [7:0] b, input int gap);
        int  n;
        bit  acc;
        repeat (gap) tick();
        if (to_b) begin
            b_in_byte = b; b_in_valid = 1'b1;
        end else begin
            a_in_byte = b; a_in_valid = 1'b1;
        end
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            acc = to_b ? b_in_ready : a_in_ready;
            tick();
            n++;
        end
        if (!acc) chk("in_ready timeout", 64'(0), 64'(1));
        if (to_b) begin
            b_in_valid = 1'b0; b_in_byte = 8'($urandom_range(0, 255));
        end else begin
            a_in_valid = 1'b0; a_in_byte = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic send_pkt_a(input logic [23:0] hdr, input logic [31:0] snd,
                              input logic [31:0] rcv, input logic [31:0] val,
                              input int max_gap, input bit push);
        logic [95:0] body;
        body = {snd, rcv, val};
        for (int i = 0; i < 3; i++) send_byte(1'b0, hdr[23-8*i -: 8], $urandom_range(0, max_gap));
        for (int i = 0; i < 12; i++) send_byte(1'b0, body[95-8*i -: 8], $urandom_range(0, max_gap));
        if (push) begin
            exp_q.push_back('{kind: 1'b0, key: snd, value: val, cmd: 2'd2});
            exp_q.push_back('{kind: 1'b1, key: rcv, value: val, cmd: 2'd2});
            total_pkts++;
            pkts_since_rst++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt < total_pkts && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(done_cnt), 64'(total_pkts));
    endtask

    task automatic check_txns(input string tag);
        while (exp_rd < exp_q.size()) begin
            if (obs_rd >= obs_q.size()) begin
                chk({tag, " txn count"}, 64'(obs_q.size()), 64'(exp_q.size()));
                obs_rd = obs_q.size();
                exp_rd = exp_q.size();
                return;
            end
            chk({tag, " kind"},  64'(obs_q[obs_rd].kind),  64'(exp_q[exp_rd].kind));
            chk({tag, " key"},   64'(obs_q[obs_rd].key),   64'(exp_q[exp_rd].key));
            chk({tag, " value"}, 64'(obs_q[obs_rd].value), 64'(exp_q[exp_rd].value));
            chk({tag, " cmd"},   64'(obs_q[obs_rd].cmd),   64'(exp_q[exp_rd].cmd));
            obs_rd++;
            exp_rd++;
        end
        chk({tag, " extra txn"}, 64'(obs_q.size()), 64'(obs_rd));
    endtask

    initial begin
        int obs_before;
        int done_before;
        logic [63:0] b_val;
        logic [31:0] s, r, v;

        rst = 1'b1;
        a_in_byte = 8'h00; a_in_valid = 1'b0; a_abort = 1'b0; a_out_ready = 1'b1;
        b_in_byte = 8'h00; b_in_valid = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        chk("rst out_valid", 64'(a_out_valid), 64'(0));
        chk("rst pkt_done",  64'(a_pkt_done),  64'(0));
        chk("rst pkt_count", 64'(a_pkt_count), 64'(0));
        chk("rst out_kind",  64'(a_out_kind),  64'(0));
        chk("rst out_key",   64'(a_out_key),   64'(0));
        chk("rst out_value", 64'(a_out_value), 64'(0));
        chk("rst out_cmd",   64'(a_out_cmd),   64'(0));
        chk("rst in_ready",  64'(a_in_ready),  64'(1));
        chk("rst b in_ready", 64'(b_in_ready), 64'(1));

        // Instance B: no header, 16-bit keys, 64-bit value.
        b_val = 64'h0102030405060708;
        send_byte(1'b1, 8'h12, 0); send_byte(1'b1, 8'h34, 0);
        send_byte(1'b1, 8'hAB, 0); send_byte(1'b1, 8'hCD, 0);
        for (int i = 0; i < 8; i++) send_byte(1'b1, b_val[63-8*i -: 8], 0);
        chk("b debit valid", 64'(b_out_valid), 64'(1));
        chk("b debit kind",  64'(b_out_kind),  64'(0));
        chk("b debit key",   64'(b_out_key),   64'h1234);
        chk("b debit value", b_out_value,      b_val);
        chk("b debit cmd",   64'(b_out_cmd),   64'(2));
        b_out_ready = 1'b1;
        tick();
        chk("b credit valid", 64'(b_out_valid), 64'(1));
        chk("b credit kind",  64'(b_out_kind),  64'(1));
        chk("b credit key",   64'(b_out_key),   64'hABCD);
        chk("b credit value", b_out_value,      b_val);
        tick();
        b_out_ready = 1'b0;
        chk("b post valid", 64'(b_out_valid), 64'(0));
        chk("b pkt_done",   64'(b_pkt_done),  64'(1));
        chk("b pkt_count",  64'(b_pkt_count), 64'(1));

        // Basic packet, downstream always ready: debit then credit back-to-back.
        do_reset();
        done_before = done_cnt;
        send_pkt_a(24'hAABBCC, 32'd5, 32'd9, 32'd500, 0, 1'b1);
        chk("basic debit valid", 64'(a_out_valid), 64'(1));
        chk("basic debit kind",  64'(a_out_kind),  64'(0));
        chk("basic debit key",   64'(a_out_key),   64'(5));
        chk("basic debit value", 64'(a_out_value), 64'(500));
        chk("basic in_ready",    64'(a_in_ready),  64'(0));
        tick();
        chk("basic credit kind", 64'(a_out_kind),  64'(1));
        chk("basic credit key",  64'(a_out_key),   64'(9));
        tick();
        chk("basic post valid",  64'(a_out_valid), 64'(0));
        chk("basic pkt_done",    64'(a_pkt_done),  64'(1));
        chk("basic pkt_count",   64'(a_pkt_count), 64'(1));
        repeat (3) tick();
        chk("basic one pulse", 64'(done_cnt - done_before), 64'(1));
        check_txns("basic");

        // Backpressure: 4 stalled cycles on the debit, 2 on the credit.
        do_reset();
        a_out_ready = 1'b0;
        obs_before = obs_q.size();
        send_pkt_a(24'hAABBCC, 32'd5, 32'd9, 32'd500, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("stall debit valid", 64'(a_out_valid), 64'(1));
            chk("stall debit kind",  64'(a_out_kind),  64'(0));
            chk("stall debit key",   64'(a_out_key),   64'(5));
            chk("stall debit value", 64'(a_out_value), 64'(500));
            chk("stall in_ready",    64'(a_in_ready),  64'(0));
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall credit valid", 64'(a_out_valid), 64'(1));
            chk("stall credit kind",  64'(a_out_kind),  64'(1));
            chk("stall credit key",   64'(a_out_key),   64'(9));
            chk("stall credit value", 64'(a_out_value), 64'(500));
            chk("stall in_ready",     64'(a_in_ready),  64'(0));
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        chk("stall post valid", 64'(a_out_valid), 64'(0));
        chk("stall pkt_count",  64'(a_pkt_count), 64'(1));
        repeat (2) tick();
        chk("stall handshakes", 64'(obs_q.size() - obs_before), 64'(2));
        check_txns("stall");

        // Abort after 6 body bytes; the byte presented with abort is dropped.
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(1'b0, 8'($urandom_range(0, 255)), 0);
        a_abort = 1'b1; a_in_valid = 1'b1; a_in_byte = 8'h77;
        tick();
        a_abort = 1'b0; a_in_valid = 1'b0;
        send_pkt_a(24'h010203, 32'd1, 32'd2, 32'd7, 1, 1'b1);
        wait_done("abort done");
        chk("abort pkt_count", 64'(a_pkt_count), 64'(1));
        check_txns("abort");

        // Reset while the debit is presented.
        do_reset();
        a_out_ready = 1'b0;
        send_pkt_a(24'h0A0B0C, 32'hDEAD, 32'hBEEF, 32'd3, 0, 1'b0);
        chk("mid-emit valid", 64'(a_out_valid), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pkts_since_rst = 0;
        chk("rst-emit out_valid", 64'(a_out_valid), 64'(0));
        chk("rst-emit pkt_count", 64'(a_pkt_count), 64'(0));
        chk("rst-emit in_ready",  64'(a_in_ready),  64'(1));
        a_out_ready = 1'b1;
        send_pkt_a(24'hFFFFFF, 32'h11, 32'h22, 32'h0, 0, 1'b1);
        wait_done("rst-emit done");
        chk("rst-emit count2", 64'(a_pkt_count), 64'(1));
        check_txns("rst-emit");

        // 17 random packets with random input gaps: counter wraps modulo 16.
        do_reset();
        for (int p = 0; p < 17; p++) begin
            s = $urandom; r = $urandom; v = (p == 3) ? 32'd0 : $urandom;
            send_pkt_a(24'($urandom), s, r, v, 3, 1'b1);
            wait_done("wrap done");
            check_txns("wrap");
            chk("wrap pkt_count", 64'(a_pkt_count), 64'(pkts_since_rst % 16));
        end
        chk("wrap final count", 64'(a_pkt_count), 64'(1));
        chk("no in_ready during emit", 64'(overlap_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
